corrector_hamming_pipe: RTL and testbench
=========================================

// Module: corrector_hamming_pipe
// PURPOSE
// - Downstream stage of detector_error in the Hamming(7,4) receive path.
// - Takes the received 7-bit word and its 3-bit syndrome, corrects any single-bit error,
//   and extracts the 4 data bits.
// - Two-stage registered pipeline with valid/ready handshake on both sides.
// - Keeps a saturating count of corrected words, for the display/LED logic.
// PARAMETERS
// - CNT_W  8  width of the corrected-word counter (saturates at 2**CNT_W-1)
// PORTS
// - clk                 in   1      single clock; all state updates on posedge
// - rst_n               in   1      asynchronous, active-low reset
// - datos_recibidos     in   7      received word [i3,i2,i1,c2,i0,c1,c0]
// - sindrome            in   3      [p2,p1,p0] from detector_error, same cycle as datos_recibidos
// - valid_in            in   1      input word/syndrome valid
// - ready_in            out  1      block can accept input this cycle
// - datos_corregidos    out  4      corrected data [i3,i2,i1,i0]
// - palabra_corregida   out  7      corrected 7-bit word
// - hubo_error          out  1      syndrome of this word was non-zero
// - bit_corregido       out  3      syndrome value: 1-based position of flipped bit (0 = none)
// - valid_out           out  1      output fields valid
// - ready_out           in   1      consumer accepts output this cycle
// - limpiar_contador    in   1      synchronous clear of contador_errores
// - contador_errores    out  CNT_W  number of words delivered with hubo_error=1
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - Both stage valids = 0 and every output = 0, including contador_errores.
//   - ready_in = 1 once reset is released.
// - Stage 1 captures {datos_recibidos, sindrome} when valid_in && ready_in.
// - Stage 2 performs the correction and holds the output registers.
// - Correction rule, with s = syndrome:
//   - s==0: word passes unchanged.
//   - s!=0: bit index s-1 is inverted. All 7 non-zero syndromes are legal; s=1,2,4
//     flip a parity bit and leave the data bits unchanged.
//   - datos_corregidos = {w[6],w[5],w[4],w[2]} of the corrected word w.
// - Handshake:
//   - A stage advances when the next stage is empty or is transferring this cycle.
//   - ready_in = !v1 || (!v2 || ready_out). Combinational, no combinational path from
//     valid_in to ready_in.
//   - valid_out = v2.
//   - Output fields stay stable while valid_out && !ready_out.
// - Latency: 2 cycles from input handshake to valid_out.
// - Throughput: 1 word/cycle while ready_out = 1.
// - Full pipeline plus ready_out = 0: ready_in = 0, nothing is lost or overwritten.
// - Simultaneous output transfer and input capture in one cycle: legal, with no bubble inserted.
// - contador_errores:
//   - Increments on the output handshake (valid_out && ready_out) when hubo_error = 1.
//   - Saturates at all-ones; no wrap-around.
//   - limpiar_contador has priority over an increment in the same cycle (that error is not counted).
// - Reset asserted mid-operation: in-flight words are dropped, with no partial output.
// - Double-bit errors are not detected: they are "corrected" per the syndrome, which is
//   inherent to Hamming(7,4).
// STRUCTURE
// - Package hamming_pkg holds:
//   - typedefs palabra_t [6:0], sindrome_t [2:0], datos_t [3:0]
//   - constant SIN_ERROR = 3'b000
//   - function extraer_datos(palabra_t) -> datos_t, shared with the encoder/detector side
// - Sub-module corrector_bit (combinational): palabra_t + sindrome_t -> corrected palabra_t.
//   Instantiated in stage 2.
// - Top file holds the two pipeline registers, the handshake logic and the counter.
// TESTING
// - 1. Clean word: datos_recibidos=7'h55, sindrome=0, ready_out=1.
//   -> 2 cycles later: datos_corregidos=4'b1011, hubo_error=0, bit_corregido=0, counter unchanged.
// - 2. Data error: 7'h45, sindrome=3'b101.
//   -> palabra_corregida=7'h55, datos_corregidos=4'b1011, hubo_error=1, bit_corregido=5,
//      counter +1.
// - 3. Parity error: 7'h54, sindrome=3'b001.
//   -> palabra_corregida=7'h55, datos_corregidos=4'b1011, hubo_error=1.
// - 4. Backpressure: ready_out=0 for 5 cycles with valid_in=1 streaming.
//   -> ready_in=0 after 2 accepts, valid_out outputs held stable.
//   -> After release, all words delivered in order with no drops or duplicates.
// - 5. Saturation: CNT_W=2, send 5 erroneous words.
//   -> contador_errores stops at 3.
//   -> limpiar_contador together with an erroneous output handshake -> counter = 0.
// - 6. Async reset pulse with both stages full.
//   -> valid_out=0 and all outputs 0 immediately.
//   -> ready_in=1 on the first edge after release.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) types and helpers for the encoder/detector/corrector path.
// Word layout: [i3,i2,i1,c2,i0,c1,c0] (bit 6 down to bit 0).
package hamming_pkg;

  localparam int unsigned PALABRA_W  = 7;
  localparam int unsigned SINDROME_W = 3;
  localparam int unsigned DATOS_W    = 4;

  typedef logic [PALABRA_W-1:0]  palabra_t;
  typedef logic [SINDROME_W-1:0] sindrome_t;
  typedef logic [DATOS_W-1:0]    datos_t;

  localparam sindrome_t SIN_ERROR = 3'b000;

  // Stage-1 payload: received word plus its syndrome.
  typedef struct packed {
    palabra_t  palabra;
    sindrome_t sindrome;
  } etapa1_t;

  // Pulls the four data bits {i3,i2,i1,i0} out of a codeword.
  function automatic datos_t extraer_datos(input palabra_t w);
    return {w[6], w[5], w[4], w[2]};
  endfunction

endpackage

// File: rtl/corrector_bit.sv
// Combinational single-bit corrector.
// Ports: palabra (received word), sindrome (1-based position of the flipped bit,
//        0 = no error), corregida_c (word with that bit inverted).
module corrector_bit
  import hamming_pkg::*;
(
  input  palabra_t  palabra,
  input  sindrome_t sindrome,
  output palabra_t  corregida_c
);

  // Syndrome value k targets bit k-1; zero matches no position.
  always_comb begin
    corregida_c = palabra;
    for (int i = 0; i < int'(PALABRA_W); i++) begin
      if (sindrome == sindrome_t'(i + 1)) begin
        corregida_c[i] = ~palabra[i];
      end
    end
  end

endmodule

// File: rtl/corrector_hamming_pipe.sv
// Two-stage Hamming(7,4) corrector with valid/ready on both sides and a
// saturating count of corrected words delivered downstream.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   datos_recibidos, sindrome  received word and its syndrome (with valid_in)
//   valid_in / ready_in        input handshake (ready_in is combinational)
//   datos_corregidos           corrected data bits [i3,i2,i1,i0]
//   palabra_corregida          corrected 7-bit word
//   hubo_error, bit_corregido  syndrome non-zero / syndrome value
//   valid_out / ready_out      output handshake
//   limpiar_contador           synchronous clear of contador_errores
//   contador_errores           delivered words that carried an error
module corrector_hamming_pipe
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       datos_recibidos,
  input  logic [2:0]       sindrome,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [3:0]       datos_corregidos,
  output logic [6:0]       palabra_corregida,
  output logic             hubo_error,
  output logic [2:0]       bit_corregido,
  output logic             valid_out,
  input  logic             ready_out,
  input  logic             limpiar_contador,
  output logic [CNT_W-1:0] contador_errores
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  etapa1_t  etapa1;
  logic     v1;
  logic     v2;
  palabra_t corregida_c;
  logic     avanza2_c;
  logic     entrega_c;

  // Stage 2 can take stage 1 when it is empty or draining this cycle.
  assign avanza2_c = !v2 || ready_out;
  assign ready_in  = !v1 || avanza2_c;
  assign entrega_c = v2 && ready_out;
  assign valid_out = v2;

  // Stage 1: capture raw word and syndrome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      etapa1 <= '0;
    end else if (ready_in) begin
      v1 <= valid_in;
      if (valid_in) begin
        etapa1 <= '{palabra: palabra_t'(datos_recibidos), sindrome: sindrome_t'(sindrome)};
      end
    end
  end

  corrector_bit u_corrector_bit (
    .palabra     (etapa1.palabra),
    .sindrome    (etapa1.sindrome),
    .corregida_c (corregida_c)
  );

  // Stage 2: corrected output registers, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2                <= 1'b0;
      palabra_corregida <= '0;
      datos_corregidos  <= '0;
      hubo_error        <= 1'b0;
      bit_corregido     <= '0;
    end else if (avanza2_c) begin
      v2 <= v1;
      if (v1) begin
        palabra_corregida <= corregida_c;
        datos_corregidos  <= extraer_datos(corregida_c);
        hubo_error        <= (etapa1.sindrome != SIN_ERROR);
        bit_corregido     <= etapa1.sindrome;
      end
    end
  end

  // Corrected-word counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador_errores <= '0;
    end else if (limpiar_contador) begin
      contador_errores <= '0;
    end else if (entrega_c && hubo_error && (contador_errores != CNT_MAX)) begin
      contador_errores <= contador_errores + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_corrector_hamming_pipe.sv
// Scoreboard bench for corrector_hamming_pipe; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_corrector_hamming_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] datos_recibidos;
  logic [2:0] sindrome;
  logic       valid_in;
  logic       ready_out;
  logic       limpiar_contador;

  logic       ready_in, valid_out, hubo_error;
  logic [3:0] datos_corregidos;
  logic [6:0] palabra_corregida;
  logic [2:0] bit_corregido;
  logic [7:0] contador_errores;

  logic       s_ready_in, s_valid_out, s_hubo_error;
  logic [3:0] s_datos_corregidos;
  logic [6:0] s_palabra_corregida;
  logic [2:0] s_bit_corregido;
  logic [1:0] s_contador_errores;

  typedef struct {
    logic [6:0] pal;
    logic [3:0] dat;
    logic       err;
    logic [2:0] bitc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt8_m   = 0;
  int   cnt2_m   = 0;

  always #5 clk = ~clk;

  corrector_hamming_pipe #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .datos_recibidos(datos_recibidos), .sindrome(sindrome),
    .valid_in(valid_in), .ready_in(ready_in), .datos_corregidos(datos_corregidos),
    .palabra_corregida(palabra_corregida), .hubo_error(hubo_error),
    .bit_corregido(bit_corregido), .valid_out(valid_out), .ready_out(ready_out),
    .limpiar_contador(limpiar_contador), .contador_errores(contador_errores)
  );

  corrector_hamming_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .datos_recibidos(datos_recibidos), .sindrome(sindrome),
    .valid_in(valid_in), .ready_in(s_ready_in), .datos_corregidos(s_datos_corregidos),
    .palabra_corregida(s_palabra_corregida), .hubo_error(s_hubo_error),
    .bit_corregido(s_bit_corregido), .valid_out(s_valid_out), .ready_out(ready_out),
    .limpiar_contador(limpiar_contador), .contador_errores(s_contador_errores)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference correction: flip bit s-1 of the received word.
  function automatic exp_t modelo(input logic [6:0] rx, input logic [2:0] s);
    exp_t       e;
    logic [6:0] w;
    w = rx;
    if (s != 3'd0) w[int'(s) - 1] = ~w[int'(s) - 1];
    e.pal  = w;
    e.dat  = {w[6], w[5], w[4], w[2]};
    e.err  = (s != 3'd0);
    e.bitc = s;
    return e;
  endfunction

  // One cycle: called just after a falling edge with inputs already driven.
  task automatic step();
    exp_t e;
    bit   acc, del;
    #1;
    acc = valid_in && ready_in && s_ready_in;
    del = valid_out && ready_out;
    if (valid_out || s_valid_out) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb[0];
        chk("valid_out", 32'(valid_out), 32'd1);
        chk("palabra", 32'(palabra_corregida), 32'(e.pal));
        chk("datos", 32'(datos_corregidos), 32'(e.dat));
        chk("hubo_error", 32'(hubo_error), 32'(e.err));
        chk("bit_corregido", 32'(bit_corregido), 32'(e.bitc));
        chk("sat_valid_out", 32'(s_valid_out), 32'd1);
        chk("sat_palabra", 32'(s_palabra_corregida), 32'(e.pal));
        chk("sat_datos", 32'(s_datos_corregidos), 32'(e.dat));
        chk("sat_hubo_error", 32'(s_hubo_error), 32'(e.err));
        chk("sat_bit", 32'(s_bit_corregido), 32'(e.bitc));
      end
    end
    e.err = 1'b0;
    if (del && sb.size() != 0) e = sb.pop_front();
    if (limpiar_contador) begin
      cnt8_m = 0;
      cnt2_m = 0;
    end else if (del && e.err) begin
      if (cnt8_m < 255) cnt8_m++;
      if (cnt2_m < 3) cnt2_m++;
    end
    if (acc) sb.push_back(modelo(datos_recibidos, sindrome));
    @(negedge clk);
    chk("contador8", 32'(contador_errores), 32'(cnt8_m));
    chk("contador2", 32'(s_contador_errores), 32'(cnt2_m));
  endtask

  task automatic send(input logic [6:0] rx, input logic [2:0] s);
    bit a = 1'b0;
    valid_in        = 1'b1;
    datos_recibidos = rx;
    sindrome        = s;
    for (int k = 0; k < 20 && !a; k++) begin
      a = ready_in;
      step();
    end
    if (!a) chk("send_timeout", 32'd1, 32'd0);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    valid_in  = 1'b0;
    ready_out = 1'b1;
    for (int k = 0; k < 50 && (sb.size() != 0 || valid_out); k++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [6:0] bp_w[5];
    logic [2:0] bp_s[5];
    int         idx;
    bit         a;

    rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1; limpiar_contador = 1'b0;
    datos_recibidos = '0; sindrome = '0;
    #3;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_palabra", 32'(palabra_corregida), 32'd0);
    chk("rst_contador", 32'(contador_errores), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready_in", 32'(ready_in), 32'd1);

    // Clean word with explicit 2-cycle latency.
    valid_in = 1'b1; datos_recibidos = 7'h55; sindrome = 3'd0;
    step();
    valid_in = 1'b0;
    chk("lat_v0", 32'(valid_out), 32'd0);
    step();
    chk("lat_v1", 32'(valid_out), 32'd1);
    chk("t1_datos", 32'(datos_corregidos), 32'hB);
    drain();
    chk("t1_contador", 32'(contador_errores), 32'd0);

    // Data-bit error and parity-bit error.
    send(7'h45, 3'b101);
    drain();
    chk("t2_contador", 32'(contador_errores), 32'd1);
    send(7'h54, 3'b001);
    drain();
    chk("t3_contador", 32'(contador_errores), 32'd2);

    // Full-throughput random stream: input accepted every cycle.
    valid_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      datos_recibidos = 7'($urandom);
      sindrome        = 3'($urandom);
      chk("thru_ready_in", 32'(ready_in), 32'd1);
      step();
    end
    drain();

    // Backpressure: two accepts fill the pipe, then ready_in drops.
    for (int i = 0; i < 5; i++) begin
      bp_w[i] = 7'($urandom);
      bp_s[i] = 3'(i + 2);
    end
    ready_out = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      valid_in = 1'b1; datos_recibidos = bp_w[idx]; sindrome = bp_s[idx];
      if (c >= 2) chk("bp_ready_in", 32'(ready_in), 32'd0);
      a = ready_in;
      step();
      if (a) idx++;
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    ready_out = 1'b1;
    for (int k = 0; k < 20 && idx < 5; k++) begin
      datos_recibidos = bp_w[idx]; sindrome = bp_s[idx];
      a = ready_in;
      step();
      if (a) idx++;
    end
    chk("bp_all_sent", 32'(idx), 32'd5);
    drain();

    // Random stream under random backpressure.
    for (int i = 0; i < 60; i++) begin
      valid_in        = 1'($urandom);
      ready_out       = 1'($urandom);
      datos_recibidos = 7'($urandom);
      sindrome        = 3'($urandom);
      step();
    end
    drain();

    // Saturation of the 2-bit counter, then clear colliding with an error delivery.
    limpiar_contador = 1'b1;
    step();
    limpiar_contador = 1'b0;
    for (int i = 0; i < 5; i++) send(7'($urandom), 3'(1 + (i % 7)));
    drain();
    chk("sat_cnt2", 32'(s_contador_errores), 32'd3);
    chk("sat_cnt8", 32'(contador_errores), 32'd5);
    send(7'h45, 3'b101);
    step();
    chk("clr_valid_out", 32'(valid_out), 32'd1);
    limpiar_contador = 1'b1;
    step();
    limpiar_contador = 1'b0;
    chk("clr_cnt2", 32'(s_contador_errores), 32'd0);
    chk("clr_cnt8", 32'(contador_errores), 32'd0);

    // Async reset with both stages full.
    ready_out = 1'b0;
    send(7'h11, 3'd3);
    send(7'h22, 3'd6);
    chk("full_ready_in", 32'(ready_in), 32'd0);
    chk("full_valid_out", 32'(valid_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid_out", 32'(valid_out), 32'd0);
    chk("arst_palabra", 32'(palabra_corregida), 32'd0);
    chk("arst_datos", 32'(datos_corregidos), 32'd0);
    chk("arst_err", 32'(hubo_error), 32'd0);
    chk("arst_bit", 32'(bit_corregido), 32'd0);
    sb.delete();
    cnt8_m = 0;
    cnt2_m = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    ready_out = 1'b1;
    step();
    chk("post_rst_ready_in", 32'(ready_in), 32'd1);
    chk("post_rst_valid_out", 32'(valid_out), 32'd0);
    send(7'h55, 3'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
